fir_decimator: RTL and testbench

Output stage placed directly downstream of the folded FIR filter. It takes the filter's per-cycle output samples and discards the filter warm-up transient. It then decimates by a fixed factor and buffers the kept samples in a small FIFO. The FIFO is drained through a valid/ready handshake, and a sticky overflow flag records any sample lost to backpressure.

---
 rtl/fir_decimator.sv | 85 ++++++++
 tb/tb_fir_decimator.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fir_decimator.sv
// fir_decimator: drops FIR warm-up samples, decimates by DECIM and buffers kept samples
// in a FIFO drained by valid/ready, with a sticky overflow flag for dropped samples.
module fir_decimator #(
  parameter int DATA_WIDTH = 16,
  parameter int DECIM      = 4,
  parameter int SETTLE     = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic signed [DATA_WIDTH-1:0]        data_in,
  input  logic                                enable,
  output logic signed [DATA_WIDTH-1:0]        m_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [$clog2(FIFO_DEPTH):0]         level,
  output logic                                overflow,
  input  logic                                clear_ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
  localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
  typedef enum logic {WARMUP, RUN} state_t;
  state_t                       state_q, state_d;
  logic [SW-1:0]                settle_q, settle_d;
  logic [PW-1:0]                phase_q, phase_d;
  logic [AW-1:0]                wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]                level_q, level_d;
  logic                         ovf_q, ovf_d;
  logic signed [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                         keep, pop, push, drop;
  // SETTLE=0 makes WARMUP behave as RUN so the first post-reset sample is kept
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    phase_d  = phase_q;
    keep     = 1'b0;
    if (state_q == WARMUP && SETTLE != 0) begin
      if (enable) begin
        settle_d = settle_q + SW'(1);
        state_d  = settle_d == SW'(SETTLE) ? RUN : WARMUP;
      end
    end else begin
      state_d = RUN;
      if (enable) begin
        keep    = phase_q == '0;
        phase_d = phase_q == PW'(DECIM - 1) ? '0 : phase_q + PW'(1);
      end
    end
    pop     = level_q != '0 && m_ready;
    push    = keep && (level_q < LW'(FIFO_DEPTH) || pop);
    drop    = keep && !push;
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    level_d = level_q + LW'(push) - LW'(pop);
    ovf_d   = drop || (ovf_q && !clear_ovf);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= WARMUP;
      settle_q <= '0;
      phase_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      phase_q  <= phase_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= data_in;
  end
  assign m_valid  = level_q != '0;
  assign m_data   = m_valid ? mem_q[rd_q] : '0;
  assign level    = level_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_fir_decimator.sv
// tb_fir_decimator: randomized and directed checks of fir_decimator against a
// sample-count / queue reference model.
module tb_fir_decimator;
  localparam int DW = 16, DECIM = 4, SETTLE = 12, DEPTH = 8, LW = $clog2(DEPTH) + 1;
  logic clk = 1'b0, reset = 1'b0, enable = 1'b0, m_ready = 1'b0, clear_ovf = 1'b0;
  logic signed [DW-1:0] data_in = '0, m_data;
  logic m_valid, overflow;
  logic [LW-1:0] level;
  int errors = 0, checks = 0;
  int n = 0;
  bit ovf = 0;
  logic signed [DW-1:0] q[$];
  fir_decimator #(.DATA_WIDTH(DW), .DECIM(DECIM), .SETTLE(SETTLE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .enable(enable), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .level(level), .overflow(overflow), .clear_ovf(clear_ovf)
  );
  always #5 clk = ~clk;
  function automatic logic [DW+LW+1:0] exp_vec();
    return {q.size() != 0, q.size() != 0 ? q[0] : DW'(0), LW'(q.size()), ovf};
  endfunction
  task automatic tick(input bit en, input int din, input bit rdy, input bit clr, input bit rst);
    bit pop, keep, drop;
    enable = en; data_in = DW'(din); m_ready = rdy; clear_ovf = clr; reset = rst;
    @(posedge clk);
    if (rst) begin
      n = 0; q.delete(); ovf = 0;
    end else begin
      pop  = q.size() != 0 && rdy;
      keep = en && n >= SETTLE && ((n - SETTLE) % DECIM == 0);
      drop = keep && q.size() == DEPTH && !pop;
      if (en) n++;
      if (pop) void'(q.pop_front());
      if (keep && !drop) q.push_back(DW'(din));
      ovf = drop || (ovf && !clr);
    end
    #1;
  endtask
  task automatic test_reset();
    tick(1, 77, 1, 0, 1);
    tick(0, 0, 0, 0, 1);
    checks++;
    if ({m_valid, m_data, level, overflow} !== '0) begin
      errors++; $display("FAIL reset_state dut=%h exp=0", {m_valid, m_data, level, overflow});
    end
  endtask
  task automatic test_ramp();
    tick(0, 0, 1, 0, 1);
    for (int k = 0; k < 40; k++) begin
      tick(1, k, 1, 0, 0);
      checks++;
      if ({m_valid, m_data, level, overflow} !== exp_vec()) begin
        errors++; $display("FAIL ramp k=%0d dut=%h exp=%h", k, {m_valid, m_data, level, overflow}, exp_vec());
      end
      if (k == 11 || k == 12) begin
        checks++;
        if ({m_valid, m_data} !== (k == 12 ? {1'b1, DW'(12)} : {1'b0, DW'(0)})) begin
          errors++; $display("FAIL ramp_first k=%0d valid=%b data=%0d", k, m_valid, m_data);
        end
      end
    end
  endtask
  task automatic test_alternate();
    int k = 0, last = -1, cyc = 0;
    tick(0, 0, 1, 0, 1);
    repeat (80) begin
      tick(cyc % 2 == 0, k, 1, 0, 0);
      if (cyc % 2 == 0) k++;
      checks++;
      if ({m_valid, m_data, level, overflow} !== exp_vec()) begin
        errors++; $display("FAIL alternate cyc=%0d dut=%h exp=%h", cyc, {m_valid, m_data, level, overflow}, exp_vec());
      end
      if (m_valid) begin
        checks++;
        if (last >= 0 && cyc - last != 8) begin
          errors++; $display("FAIL alternate_spacing got=%0d exp=8", cyc - last);
        end
        last = cyc;
      end
      cyc++;
    end
  endtask
  task automatic test_overflow();
    tick(0, 0, 0, 0, 1);
    for (int k = 0; k < 48; k++) begin
      tick(1, k, 0, 0, 0);
      checks++;
      if ({m_valid, m_data, level, overflow} !== exp_vec()) begin
        errors++; $display("FAIL ovf_fill k=%0d dut=%h exp=%h", k, {m_valid, m_data, level, overflow}, exp_vec());
      end
      if (k == 40 || k == 44) begin
        checks++;
        if (level !== LW'(8) || overflow !== (k == 44)) begin
          errors++; $display("FAIL ovf_point k=%0d level=%0d ovf=%b", k, level, overflow);
        end
      end
    end
    for (int k = 48; k < 90; k++) begin
      tick(1, k, 1, 0, 0);
      checks++;
      if ({m_valid, m_data, level, overflow} !== exp_vec() || (m_valid && m_data == 44)) begin
        errors++; $display("FAIL ovf_drain k=%0d dut=%h exp=%h", k, {m_valid, m_data, level, overflow}, exp_vec());
      end
    end
  endtask
  task automatic test_full_pop();
    tick(0, 0, 0, 0, 1);
    for (int k = 0; k < 64; k++) begin
      tick(1, k, k >= 44, 0, 0);
      checks++;
      if ({m_valid, m_data, level, overflow} !== exp_vec()) begin
        errors++; $display("FAIL full_pop k=%0d dut=%h exp=%h", k, {m_valid, m_data, level, overflow}, exp_vec());
      end
      if (k == 44) begin
        checks++;
        if (level !== LW'(8) || overflow !== 1'b0 || m_data !== DW'(16)) begin
          errors++; $display("FAIL full_pop_edge level=%0d ovf=%b data=%0d exp 8/0/16", level, overflow, m_data);
        end
      end
    end
  endtask
  task automatic test_clear_ovf();
    tick(0, 0, 0, 0, 1);
    for (int k = 0; k <= 44; k++) tick(1, k, 0, k == 44, 0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL clear_same_cycle ovf=%b exp=1", overflow);
    end
    tick(0, 0, 0, 1, 0);
    checks++;
    if (overflow !== 1'b0 || level !== LW'(8)) begin
      errors++; $display("FAIL clear_idle ovf=%b level=%0d exp 0/8", overflow, level);
    end
  endtask
  task automatic test_reset_mid();
    tick(0, 0, 0, 0, 1);
    for (int k = 0; k <= 28; k++) tick(1, k, 0, 0, 0);
    checks++;
    if (level !== LW'(5)) begin
      errors++; $display("FAIL mid_level level=%0d exp=5", level);
    end
    tick(1, 29, 0, 0, 1);
    checks++;
    if ({m_valid, m_data, level} !== '0) begin
      errors++; $display("FAIL mid_reset dut=%h exp=0", {m_valid, m_data, level});
    end
    for (int k = 0; k <= 12; k++) begin
      tick(1, 100 + k, 1, 0, 0);
      checks++;
      if ({m_valid, m_data} !== (k == 12 ? {1'b1, DW'(112)} : {1'b0, DW'(0)})) begin
        errors++; $display("FAIL mid_rewarm k=%0d valid=%b data=%0d", k, m_valid, m_data);
      end
    end
  endtask
  task automatic test_random();
    tick(0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 3) != 0, int'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 499) == 0);
      checks++;
      if ({m_valid, m_data, level, overflow} !== exp_vec()) begin
        errors++; $display("FAIL random i=%0d dut=%h exp=%h", i, {m_valid, m_data, level, overflow}, exp_vec());
      end
    end
  endtask
  initial begin
    test_reset();
    test_ramp();
    test_alternate();
    test_overflow();
    test_full_pop();
    test_clear_ovf();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
